// File: rtl/mac3_frame_driver.sv
// mac3_frame_driver: sends an (a, b, c) triple as three validi beats, waits for valido,
// and reports whether the returned result equals a*b+c mod 2^DW.
module mac3_frame_driver #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 8
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   input  logic [DW-1:0] req_c,
   output logic          validi,
   output logic [DW-1:0] data_in,
   input  logic          valido,
   input  logic [DW-1:0] data_out,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_ok,
   output logic          rsp_timeout,
   output logic          err_spurious
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, SEND_C, WAIT, REPORT} state_t;
   state_t        state;
   logic [DW-1:0] ra, rb, rc, expect_q;
   logic [CW-1:0] cnt;
   // Outputs are loaded with next-state values so every port is a flop.
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         validi       <= 1'b0;
         data_in      <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_ok       <= 1'b0;
         rsp_timeout  <= 1'b0;
         err_spurious <= 1'b0;
         ra           <= '0;
         rb           <= '0;
         rc           <= '0;
         expect_q     <= '0;
         cnt          <= '0;
      end else begin
         if (valido && state != WAIT) err_spurious <= 1'b1;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  ra        <= req_a;
                  rb        <= req_b;
                  rc        <= req_c;
                  req_ready <= 1'b0;
                  validi    <= 1'b1;
                  data_in   <= req_a;
                  state     <= SEND_A;
               end
            end
            SEND_A: begin
               data_in <= rb;
               state   <= SEND_B;
            end
            SEND_B: begin
               data_in <= rc;
               state   <= SEND_C;
            end
            SEND_C: begin
               validi   <= 1'b0;
               data_in  <= '0;
               expect_q <= ra * rb + rc;
               cnt      <= CW'(1);
               state    <= WAIT;
            end
            WAIT: begin
               // A valido on the final counted cycle still wins over the timeout.
               if (valido || cnt == CW'(TIMEOUT)) begin
                  rsp_valid   <= 1'b1;
                  rsp_data    <= valido ? data_out : '0;
                  rsp_ok      <= valido && data_out == expect_q;
                  rsp_timeout <= !valido;
                  state       <= REPORT;
               end else cnt <= cnt + 1'b1;
            end
            REPORT: begin
               rsp_valid   <= 1'b0;
               rsp_data    <= '0;
               rsp_ok      <= 1'b0;
               rsp_timeout <= 1'b0;
               req_ready   <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_mac3_frame_driver.sv
// tb_mac3_frame_driver: table-driven and randomized frames against an arithmetic reference,
// acting as the downstream multiply-add unit.
module tb_mac3_frame_driver;
   localparam int DW = 32;
   localparam int TIMEOUT = 8;

   logic          clk = 1'b0, rst_ = 1'b0, req_valid = 1'b0, valido = 1'b0;
   logic [DW-1:0] req_a = '0, req_b = '0, req_c = '0, data_out = '0;
   logic          req_ready, validi, rsp_valid, rsp_ok, rsp_timeout, err_spurious;
   logic [DW-1:0] data_in, rsp_data;
   int            cyc = 0, n_chk = 0, n_fail = 0;
   bit            exp_spur = 1'b0;

   mac3_frame_driver #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .validi(validi), .data_in(data_in),
      .valido(valido), .data_out(data_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [DW-1:0] a, b, c;
      int            dly;
      logic [DW-1:0] ret;
      bit            ok;
   } vec_t;

   function automatic logic [DW-1:0] model(input logic [DW-1:0] a, b, c);
      logic [63:0] p;
      p = (64'(a) * 64'(b)) % (64'd1 << DW);
      return DW'((p + 64'(c)) % (64'd1 << DW));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic apply_reset(input int n);
      rst_ = 1'b0;
      req_valid = 1'b0;
      valido = 1'b0;
      exp_spur = 1'b0;
      repeat (n) @(negedge clk);
      chk("reset_outputs", {req_ready, validi, data_in, rsp_valid, rsp_data, rsp_ok, rsp_timeout, err_spurious}, '0);
      rst_ = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1'b1);
   endtask

   // dly: cycles after T+4 at which valido is returned; -1 means never.
   task automatic do_frame(input logic [DW-1:0] a, b, c, input int dly, input logic [DW-1:0] ret, input bit exp_ok);
      int t, exp_off;
      bit got, rcv;
      rcv = dly >= 0 && dly < TIMEOUT;
      exp_off = rcv ? 5 + dly : 4 + TIMEOUT;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      chk("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
      t = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      chk("beat_a", {validi, data_in}, {1'b1, a});
      chk("busy_not_ready", req_ready, 1'b0);
      @(negedge clk);
      chk("beat_b", {validi, data_in}, {1'b1, b});
      @(negedge clk);
      chk("beat_c", {validi, data_in}, {1'b1, c});
      got = 1'b0;
      for (int k = 0; k < TIMEOUT + 4 && !got; k++) begin
         @(negedge clk);
         if (k == 0) chk("gap_after_frame", {validi, data_in}, '0);
         if (rsp_valid) begin
            got = 1'b1;
            valido = 1'b0;
         end else begin
            valido = (k == dly);
            data_out = ret;
         end
      end
      valido = 1'b0;
      chk("rsp_seen", got, 1'b1);
      chk("rsp_cycle", cyc - t, exp_off);
      chk("rsp_data", rsp_data, rcv ? ret : '0);
      chk("rsp_ok", rsp_ok, exp_ok);
      chk("rsp_timeout", rsp_timeout, !rcv);
      chk("err_spurious", err_spurious, exp_spur);
      @(negedge clk);
      chk("rsp_one_cycle", {rsp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      vec_t tbl[$];
      int   first_ready, t;
      bit   bb_ok;
      logic [DW-1:0] a, b, c, m, r;
      int   d;
      tbl.push_back('{32'd3, 32'd4, 32'd5, 0, 32'd17, 1'b1});
      tbl.push_back('{32'hFFFF_FFFF, 32'd2, 32'd3, 0, 32'd1, 1'b1});
      tbl.push_back('{32'd3, 32'd4, 32'd5, 0, 32'd16, 1'b0});
      tbl.push_back('{32'd3, 32'd4, 32'd5, -1, 32'd17, 1'b0});
      tbl.push_back('{32'd3, 32'd4, 32'd5, TIMEOUT - 1, 32'd17, 1'b1});
      tbl.push_back('{32'h0001_0000, 32'h0001_0000, 32'd7, 2, 32'd7, 1'b1});
      tbl.push_back('{32'd5, 32'd6, 32'hFFFF_FFFF, 1, 32'd29, 1'b1});

      @(negedge clk);
      apply_reset(3);
      foreach (tbl[i]) do_frame(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].dly, tbl[i].ret, tbl[i].ok);

      for (int i = 0; i < 20; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         if (i % 4 == 0) b = $urandom_range(0, 3);
         m = model(a, b, c);
         d = $urandom_range(0, TIMEOUT + 1);
         if (d == TIMEOUT + 1) d = -1;
         r = $urandom_range(0, 2) == 0 ? m ^ DW'($urandom_range(1, 255)) : m;
         do_frame(a, b, c, d, r, d >= 0 && d < TIMEOUT && r == m);
      end

      // Spurious valido while idle sets a sticky flag that survives later good frames.
      valido = 1'b1;
      @(negedge clk);
      valido = 1'b0;
      exp_spur = 1'b1;
      @(negedge clk);
      chk("spurious_set", err_spurious, 1'b1);
      do_frame(32'd3, 32'd4, 32'd5, 0, 32'd17, 1'b1);
      do_frame(32'd7, 32'd8, 32'd9, 1, 32'd65, 1'b1);
      apply_reset(2);
      chk("spurious_cleared", err_spurious, 1'b0);

      // Reset during SEND_B aborts the frame without a response.
      req_valid = 1'b1; req_a = 32'd11; req_b = 32'd12; req_c = 32'd13;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("midreset_send_b", {validi, data_in}, {1'b1, 32'd12});
      #1 rst_ = 1'b0;
      #1 chk("midreset_validi_async", validi, 1'b0);
      bb_ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2) rst_ = 1'b1;
         if (rsp_valid) bb_ok = 1'b1;
      end
      chk("midreset_no_rsp", bb_ok, 1'b0);
      do_frame(32'd3, 32'd4, 32'd5, 0, 32'd17, 1'b1);

      // Back-to-back with req_valid held: second triple accepted in T+6.
      req_valid = 1'b1; req_a = 32'd3; req_b = 32'd4; req_c = 32'd5;
      t = cyc;
      first_ready = 0;
      bb_ok = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) begin req_a = 32'd20; req_b = 32'd30; req_c = 32'd40; end
         valido = (k == 4);
         data_out = 32'd17;
         if (k == 5) bb_ok = rsp_valid && rsp_ok;
         if (req_ready && first_ready == 0) first_ready = cyc - t;
      end
      req_valid = 1'b0;
      valido = 1'b0;
      chk("b2b_first_rsp", bb_ok, 1'b1);
      chk("b2b_ready_cycle", first_ready, 6);
      chk("b2b_second_beat_a", {validi, data_in}, {1'b1, 32'd20});
      apply_reset(2);
      do_frame(32'd20, 32'd30, 32'd40, 0, model(32'd20, 32'd30, 32'd40), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
